// File: rtl/mips_pkg.sv
// Shared decode/execute definitions: ALU opcodes, datapath width and the
// multiply/divide unit state encoding.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] MULT_OP = 6'h02;
    localparam logic [5:0] DIV_OP  = 6'h03;
    localparam logic [5:0] MFHI_OP = 6'h04;
    localparam logic [5:0] MFLO_OP = 6'h05;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between decode and the multiply/divide unit.
interface muldiv_unit_if;
    import mips_pkg::*;

    logic            valid;
    logic [5:0]      aluop;
    logic            is_signed;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            stall;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            div_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output valid, aluop, is_signed, rs_val, rt_val,
        input  stall, busy, result, result_valid, div_zero, hi, lo
    );

    modport slave (
        input  valid, aluop, is_signed, rs_val, rt_val,
        output stall, busy, result, result_valid, div_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned iterative core: operand magnitudes at accept,
// conditional negation of product / quotient / remainder at the final fix-up.
module muldiv_signfix
    import mips_pkg::*;
(
    input  logic              is_signed_i,
    input  logic [XLEN-1:0]   rs_i,
    input  logic [XLEN-1:0]   rt_i,
    output logic              neg_a_o,
    output logic              neg_b_o,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic              op_div_i,
    input  logic              neg_res_i,
    input  logic              neg_rem_i,
    output logic [XLEN-1:0]   hi_o,
    output logic [XLEN-1:0]   lo_o
);

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign neg_a_o = is_signed_i & rs_i[XLEN-1];
    assign neg_b_o = is_signed_i & rt_i[XLEN-1];
    assign mag_a_o = neg_a_o ? -rs_i : rs_i;
    assign mag_b_o = neg_b_o ? -rt_i : rt_i;

    // Divide packs {remainder, quotient} into the accumulator halves.
    assign prod_fix = neg_res_i ? -acc_i : acc_i;
    assign quo_fix  = neg_res_i ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
    assign rem_fix  = neg_rem_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];

    assign hi_o = op_div_i ? rem_fix : prod_fix[2*XLEN-1:XLEN];
    assign lo_o = op_div_i ? quo_fix : prod_fix[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO, one
// result bit per cycle, sign fix-up in a final cycle.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus_io
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              op_div_q, op_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;

    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b, fix_hi, fix_lo;
    logic              is_md, is_mf, busy, accept, last_iter;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub, div_rem;

    muldiv_signfix u_signfix (
        .is_signed_i (bus_io.is_signed),
        .rs_i        (bus_io.rs_val),
        .rt_i        (bus_io.rt_val),
        .neg_a_o     (neg_a),
        .neg_b_o     (neg_b),
        .mag_a_o     (mag_a),
        .mag_b_o     (mag_b),
        .acc_i       (acc_q),
        .op_div_i    (op_div_q),
        .neg_res_i   (neg_res_q),
        .neg_rem_i   (neg_rem_q),
        .hi_o        (fix_hi),
        .lo_o        (fix_lo)
    );

    assign is_md     = (bus_io.aluop == MULT_OP) || (bus_io.aluop == DIV_OP);
    assign is_mf     = (bus_io.aluop == MFHI_OP) || (bus_io.aluop == MFLO_OP);
    assign busy      = (state_q != StIdle);
    assign accept    = bus_io.valid && !busy && is_md;
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // Shift-add: acc = {product high, remaining multiplier bits}.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Restoring step: acc = {partial remainder, dividend/quotient bits}.
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = div_shift[XLEN] || (div_shift[XLEN-1:0] >= opb_q);
    assign div_sub   = div_shift[XLEN-1:0] - opb_q;
    assign div_rem   = div_ge ? div_sub : div_shift[XLEN-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_div_d  = op_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_div_d  = (bus_io.aluop == DIV_OP);
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    dz_d      = 1'b0;
                    cnt_d     = '0;
                    if (bus_io.aluop == DIV_OP) begin
                        opb_d = mag_b;
                        acc_d = {{XLEN{1'b0}}, mag_a};
                        state_d = StDiv;
                        if (bus_io.rt_val == '0) begin
                            // Raw dividend to HI, all-ones to LO, no sign fix-up.
                            acc_d     = {bus_io.rs_val, {XLEN{1'b1}}};
                            neg_res_d = 1'b0;
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b1;
                            state_d   = StFix;
                        end
                    end else begin
                        opb_d   = mag_a;
                        acc_d   = {{XLEN{1'b0}}, mag_b};
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = StFix;
            end
            StDiv: begin
                acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = StFix;
            end
            StFix: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                dz_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_div_q  <= op_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign bus_io.busy         = busy;
    assign bus_io.stall        = bus_io.valid && busy && (is_md || is_mf);
    assign bus_io.result       = (bus_io.aluop == MFHI_OP) ? hi_q : lo_q;
    assign bus_io.result_valid = bus_io.valid && !busy && is_mf;
    assign bus_io.div_zero     = (state_q == StFix) && dz_q;
    assign bus_io.hi           = hi_q;
    assign bus_io.lo           = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, scoreboard, hazard and reset sequences.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    muldiv_unit_if bus ();

    muldiv_unit #(.CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic sgn,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        int          sa, sbv;
        sa  = a;
        sbv = b;
        if (op == MULT_OP) begin
            if (sgn) begin
                sp = longint'(sa) * longint'(sbv);
                up = sp;
            end else begin
                up = {32'd0, a} * {32'd0, b};
            end
            e.hi = up[63:32];
            e.lo = up[31:0];
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else if (sgn) begin
            e.lo = sa / sbv;
            e.hi = sa % sbv;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Starts at a negedge; returns at the first negedge with busy low.
    task automatic run_op(input string name, input vec_t v);
        exp_t got, e;
        int   n, d;
        e.hi = v.hi;
        e.lo = v.lo;
        sb.push_back(e);
        bus.valid = 1'b1;
        bus.aluop = v.op;
        bus.is_signed = v.sgn;
        bus.rs_val = v.a;
        bus.rt_val = v.b;
        #1 check({name, " stall@issue"}, 64'(bus.stall), 64'd0);
        @(negedge clock);
        bus.valid = 1'b0;
        bus.aluop = 6'h00;
        bus.rs_val = ~v.a;
        bus.rt_val = v.a ^ v.b;
        n = 0;
        d = 0;
        while (bus.busy && n < 64) begin
            if (bus.div_zero) d++;
            n++;
            @(negedge clock);
        end
        check({name, " busy_cycles"}, 64'(n), 64'(v.cyc));
        check({name, " div_zero_pulses"}, 64'(d), 64'(v.dz));
        got.hi = bus.hi;
        got.lo = bus.lo;
        e = sb.pop_front();
        check({name, " hi"}, 64'(got.hi), 64'(e.hi));
        check({name, " lo"}, 64'(got.lo), 64'(e.lo));
    endtask

    task automatic mf(input string name, input logic [5:0] op, input logic [31:0] exp);
        bus.valid = 1'b1;
        bus.aluop = op;
        #1;
        check({name, " result_valid"}, 64'(bus.result_valid), 64'd1);
        check({name, " stall"}, 64'(bus.stall), 64'd0);
        check({name, " result"}, 64'(bus.result), 64'(exp));
        @(negedge clock);
        bus.valid = 1'b0;
        bus.aluop = 6'h00;
        #1 check({name, " busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    vec_t        tbl[10];
    vec_t        rv;
    exp_t        me;
    logic [31:0] known_hi, known_lo;
    int          n;

    initial begin
        tbl[0] = '{MULTU_OP_FIX(MULT_OP), 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0};
        tbl[1] = '{DIV_OP,  1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0};
        tbl[2] = '{DIV_OP,  1'b0, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 33, 0};
        tbl[3] = '{DIV_OP,  1'b1, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 1,  1};
        tbl[4] = '{DIV_OP,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 0};
        tbl[5] = '{DIV_OP,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33, 0};
        tbl[6] = '{MULT_OP, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 0};
        tbl[7] = '{DIV_OP,  1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 0};
        tbl[8] = '{DIV_OP,  1'b1, 32'h8000_0001, 32'd0,        32'h8000_0001, 32'hFFFF_FFFF, 1,  1};
        tbl[9] = '{MULT_OP, 1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 0};

        bus.valid = 1'b0;
        bus.aluop = 6'h00;
        bus.is_signed = 1'b0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (3) @(negedge clock);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i]);
        end
        mf("mflo", MFLO_OP, 32'hFFFF_FFEB);
        mf("mfhi", MFHI_OP, 32'hFFFF_FFFF);
        known_hi = 32'hFFFF_FFFF;
        known_lo = 32'hFFFF_FFEB;

        // Unrelated opcode: no stall, no result, no state change.
        bus.valid = 1'b1;
        bus.aluop = 6'h01;
        #1;
        check("other stall", 64'(bus.stall), 64'd0);
        check("other result_valid", 64'(bus.result_valid), 64'd0);
        @(negedge clock);
        bus.valid = 1'b0;
        check("other busy", 64'(bus.busy), 64'd0);

        // Hazard: MFHI then a second MULTU held while the first is in flight.
        bus.valid = 1'b1;
        bus.aluop = MULT_OP;
        bus.is_signed = 1'b0;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd5;
        @(negedge clock);
        bus.aluop = MFHI_OP;
        bus.rs_val = 32'd6;
        bus.rt_val = 32'd7;
        n = 0;
        while (bus.busy && n < 64) begin
            if (n == 5) bus.aluop = MULT_OP;
            #1;
            if (n == 2 || n == 8 || n == 32) begin
                check($sformatf("hazard stall n=%0d", n), 64'(bus.stall), 64'd1);
                check($sformatf("hazard rvalid n=%0d", n), 64'(bus.result_valid), 64'd0);
                check($sformatf("hazard hi n=%0d", n), 64'(bus.hi), 64'(known_hi));
                check($sformatf("hazard lo n=%0d", n), 64'(bus.lo), 64'(known_lo));
            end
            n++;
            @(negedge clock);
        end
        check("hazard busy_cycles", 64'(n), 64'd33);
        check("hazard first lo", 64'(bus.lo), 64'd15);
        check("hazard first hi", 64'(bus.hi), 64'd0);
        check("hazard stall idle", 64'(bus.stall), 64'd0);
        @(negedge clock);
        check("hazard second accepted", 64'(bus.busy), 64'd1);
        bus.valid = 1'b0;
        n = 0;
        while (bus.busy && n < 64) begin
            n++;
            @(negedge clock);
        end
        check("hazard second cycles", 64'(n), 64'd33);
        check("hazard second lo", 64'(bus.lo), 64'd42);

        // Reset in the middle of a divide.
        bus.valid = 1'b1;
        bus.aluop = DIV_OP;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        @(negedge clock);
        bus.valid = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset hi", 64'(bus.hi), 64'd0);
        check("midreset lo", 64'(bus.lo), 64'd0);
        repeat (40) @(negedge clock);
        check("midreset no late write", 64'({bus.hi, bus.lo}), 64'd0);

        // Randomised operations against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            rv.op  = ($urandom_range(0, 1) == 0) ? MULT_OP : DIV_OP;
            rv.sgn = 1'($urandom_range(0, 1));
            rv.a   = $urandom;
            rv.b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (rv.sgn && rv.a == 32'h8000_0000 && rv.b == 32'hFFFF_FFFF) rv.b = 32'd3;
            me     = model(rv.op, rv.sgn, rv.a, rv.b);
            rv.hi  = me.hi;
            rv.lo  = me.lo;
            rv.cyc = (rv.op == DIV_OP && rv.b == 32'd0) ? 1 : 33;
            rv.dz  = (rv.op == DIV_OP && rv.b == 32'd0) ? 1 : 0;
            run_op($sformatf("rand%0d", i), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic [5:0] MULTU_OP_FIX(input logic [5:0] op);
        return op;
    endfunction

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
- Consumes the MULT_OP, DIV_OP, MFHI_OP and MFLO_OP control codes produced by the decode stage and executes them iteratively.
- Sits beside the ALU in execute.
- Raises a stall toward decode/fetch while an operation is in flight; returns HI/LO for MFHI/MFLO.

Parameters:
- XLEN, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- valid  in  1  instruction present this cycle with aluop qualified
- aluop  in  6  decode ALU opcode; only MULT_OP=6'h02, DIV_OP=6'h03, MFHI_OP=6'h04, MFLO_OP=6'h05 are acted on
- is_signed  in  1  1 = MULT/DIV, 0 = MULTU/DIVU (funct bit0 inverted, driven by decode)
- rs_val  in  XLEN  operand A (multiplicand / dividend)
- rt_val  in  XLEN  operand B (multiplier / divisor)
- stall  out  1  upstream must hold the instruction
- busy  out  1  operation in flight
- result  out  XLEN  HI or LO for MFHI/MFLO
- result_valid  out  1  result is meaningful this cycle
- div_zero  out  1  one-cycle pulse when a divide by zero completes
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE; hi=lo=0; busy=0; div_zero=0; counter=0.
  - Aborts any in-flight operation; no HI/LO update.
- States: IDLE, MUL, DIV, FIX.
- Accept: valid && state==IDLE && aluop∈{MULT_OP,DIV_OP} at edge T.
  - Operands are latched.
  - Signed mode: magnitudes are taken and result signs recorded.
  - Next state is MUL or DIV with counter=0.
- MUL: radix-2 shift-add on unsigned magnitudes.
  - 64-bit product register; one multiplier bit per cycle.
  - XLEN cycles (edges T+1..T+32), then FIX.
- DIV: restoring division on unsigned magnitudes.
  - 33-bit partial remainder; one quotient bit per cycle.
  - XLEN cycles, then FIX.
- FIX (edge T+33): applies signs and writes HI/LO, then returns to IDLE.
  - MUL: {HI,LO} = product, negated (two's complement, 64-bit) if signs differ.
  - DIV: LO = quotient, negated if operand signs differ; HI = remainder, with the dividend's sign.
  - 0x80000000 / -1 signed gives LO=0x80000000, HI=0.
- Divide by zero (rt_val==0 at accept):
  - Goes directly to FIX (no iterations).
  - HI = rs_val (raw), LO = 0xFFFFFFFF.
  - div_zero pulses for the FIX cycle.
- busy: registered; 1 in MUL/DIV/FIX, 0 in IDLE.
  - hi/lo are updated at the same edge busy falls.
- stall = valid && busy && aluop∈{MULT_OP,DIV_OP,MFHI_OP,MFLO_OP}; combinational.
  - A new MULT/DIV issued while busy is not accepted; it is accepted the first IDLE cycle it is still presented.
- MFHI/MFLO:
  - result = hi or lo (combinational mux of the registers).
  - result_valid = valid && !busy && aluop∈{MFHI_OP,MFLO_OP}.
  - While busy: result_valid=0 and stall=1.
  - MFHI/MFLO never change state.
- Other aluop values, or valid=0: no effect; stall=0; result_valid=0; result is don't-care (drive lo).
- Back-to-back: MULT/DIV accepted the cycle after FIX (IDLE) is legal; throughput is one op per 34 cycles.
- Operands are sampled only at accept; rs_val/rt_val changes during MUL/DIV are ignored.

Decomposition:
- Package mips_pkg holds:
  - aluop constants (all *_OP codes shared with decode and ALU), including MULT_OP, DIV_OP, MFHI_OP, MFLO_OP;
  - the state enum;
  - XLEN.
- One natural sub-module: muldiv_signfix.
  - Combinational magnitude/negate helper used at accept (abs) and at FIX (conditional negate, 32 and 64 bit).
- Datapath and FSM stay in muldiv_unit.

Test Plan:
- Signed multiply: MULT, is_signed=1, rs=7, rt=0xFFFFFFFD (−3) -> busy for 33 cycles; at T+33 HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MFLO -> result=0xFFFFFFEB, result_valid=1.
- Unsigned multiply: MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide: DIV rs=0xFFFFFFF9 (−7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divide: DIVU rs=100, rt=7 -> LO=0x0000000E, HI=0x00000002.
- Divide by zero: DIV rs=5, rt=0 -> FIX at T+1; HI=5, LO=0xFFFFFFFF; div_zero=1 for exactly one cycle.
- Hazard and reset:
  - MFHI and a second MULT presented during busy -> stall=1, result_valid=0, HI/LO unchanged until FIX; second MULT accepted the cycle after busy falls.
  - reset_n=0 at T+10 of a DIV -> next cycle IDLE, busy=0, HI=LO=0.
